// File: rtl/multi_channel_requester.sv
// Multi-channel request capture with round-robin issue into a NoC request FIFO.
// Optional statistics counters (issue_count, stall_count) are built when REQ_STATS_EN is defined.
module multi_channel_requester #(
    parameter int ID    = 0,
    parameter int WIDTH = 16,
    parameter int NCH   = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  full,
    input  logic                                  almost_full,
    input  logic [NCH*WIDTH-1:0]                  request,
    output logic [WIDTH-1:0]                      dataOut,
    output logic                                  write,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] issue_ch,
    output logic [NCH-1:0]                        pending
`ifdef REQ_STATS_EN
    ,
    output logic [15:0]                           issue_count,
    output logic [15:0]                           stall_count
`endif
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [WIDTH-1:0] req_word        [NCH];
    logic [WIDTH-1:0] hold_reg        [NCH];
    logic [WIDTH-1:0] pre_request_reg [NCH];
    logic [NCH-1:0]   capture;
    logic [CW-1:0]    last_grant_reg;

    logic             stall;
    logic             issue_fire;
    logic             grant_valid;
    logic [CW-1:0]    grant_idx;
    logic [NCH-1:0]   grant_onehot;
    logic [NCH-1:0]   issue_mask;
    logic [WIDTH-1:0] grant_data;
    int               rr_slot;

    // ID identifies the node to the surrounding system only; nothing here depends on it.
    if (ID < 0) begin : g_id_reserved
    end

    // A word is captured only when it is valid, differs from the last captured word,
    // and the channel's previous capture has already been issued.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        assign req_word[gi] = request[gi*WIDTH +: WIDTH];
        assign capture[gi]  = req_word[gi][0] && (req_word[gi] != pre_request_reg[gi]) && !pending[gi];
    end

    assign stall      = (write & almost_full) | (~write & full);
    assign issue_fire = ~stall & grant_valid;
    assign issue_mask = grant_onehot & {NCH{issue_fire}};

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        grant_valid  = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        grant_data   = '0;
        rr_slot      = 0;
        for (int k = 0; k < NCH; k++) begin
            rr_slot = int'(last_grant_reg) + 1 + k;
            if (rr_slot >= NCH) begin
                rr_slot = rr_slot - NCH;
            end
            for (int j = 0; j < NCH; j++) begin
                if (!grant_valid && (rr_slot == j) && pending[j]) begin
                    grant_valid     = 1'b1;
                    grant_idx       = CW'(j);
                    grant_onehot[j] = 1'b1;
                    grant_data      = hold_reg[j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write          <= 1'b0;
            dataOut        <= '0;
            issue_ch       <= '0;
            pending        <= '0;
            last_grant_reg <= CW'(NCH - 1);
            for (int c = 0; c < NCH; c++) begin
                hold_reg[c]        <= '0;
                pre_request_reg[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (capture[c]) begin
                    hold_reg[c]        <= req_word[c];
                    pre_request_reg[c] <= req_word[c];
                end
            end
            // Capture and issue masks never overlap: capture needs pending clear, issue needs it set.
            pending <= (pending & ~issue_mask) | capture;
            if (issue_fire) begin
                write          <= 1'b1;
                dataOut        <= grant_data;
                issue_ch       <= grant_idx;
                last_grant_reg <= grant_idx;
            end else begin
                write   <= 1'b0;
                dataOut <= '0;
            end
        end
    end

`ifdef REQ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_count <= '0;
            stall_count <= '0;
        end else begin
            if (write) begin
                issue_count <= issue_count + 16'd1;
            end
            if ((|pending) && stall && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multi_channel_requester.sv
// Bench for multi_channel_requester: directed scenarios plus random traffic,
// all checked every cycle against a behavioural model of the request/issue rules.
module tb_multi_channel_requester;

    localparam int WIDTH = 16;
    localparam int NCH   = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   full;
    logic                   almost_full;
    logic [NCH*WIDTH-1:0]   request;
    logic [WIDTH-1:0]       dataOut;
    logic                   write;
    logic [1:0]             issue_ch;
    logic [NCH-1:0]         pending;
`ifdef REQ_STATS_EN
    logic [15:0]            issue_count;
    logic [15:0]            stall_count;
`endif

    multi_channel_requester #(.ID(3), .WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk         (clk),
        .reset       (reset),
        .full        (full),
        .almost_full (almost_full),
        .request     (request),
        .dataOut     (dataOut),
        .write       (write),
        .issue_ch    (issue_ch),
        .pending     (pending)
`ifdef REQ_STATS_EN
        ,
        .issue_count (issue_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit verbose  = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_pend [NCH];
    logic [15:0] m_hold [NCH];
    logic [15:0] m_pre  [NCH];
    bit          m_write;
    logic [15:0] m_data;
    int          m_ch;
    int          m_last;
    int          m_issue_cnt;
    int          m_stall_cnt;

    task automatic model_step(input bit r, input bit f, input bit af, input logic [NCH*WIDTH-1:0] req);
        bit          stall;
        bit          any_pend;
        bit          cap [NCH];
        int          g;
        logic [15:0] w;
        if (r) begin
            for (int c = 0; c < NCH; c++) begin
                m_pend[c] = 1'b0;
                m_hold[c] = '0;
                m_pre[c]  = '0;
            end
            m_write = 1'b0; m_data = '0; m_ch = 0; m_last = NCH - 1;
            m_issue_cnt = 0; m_stall_cnt = 0;
            return;
        end
        stall    = (m_write && af) || (!m_write && f);
        any_pend = 1'b0;
        for (int c = 0; c < NCH; c++) any_pend |= m_pend[c];
        if (m_write) m_issue_cnt = (m_issue_cnt + 1) % 65536;
        if (any_pend && stall && m_stall_cnt < 65535) m_stall_cnt++;
        for (int c = 0; c < NCH; c++) begin
            w      = req[c*WIDTH +: WIDTH];
            cap[c] = w[0] && (w != m_pre[c]) && !m_pend[c];
        end
        g = -1;
        if (!stall) begin
            for (int k = 0; k < NCH; k++) begin
                if (g < 0 && m_pend[(m_last + 1 + k) % NCH]) g = (m_last + 1 + k) % NCH;
            end
        end
        if (g >= 0) begin
            m_write = 1'b1; m_data = m_hold[g]; m_ch = g; m_last = g; m_pend[g] = 1'b0;
        end else begin
            m_write = 1'b0; m_data = '0;
        end
        for (int c = 0; c < NCH; c++) begin
            if (cap[c]) begin
                m_pend[c] = 1'b1;
                m_hold[c] = req[c*WIDTH +: WIDTH];
                m_pre[c]  = req[c*WIDTH +: WIDTH];
            end
        end
    endtask

    // Compare process: sample inputs at the edge, compare outputs 1 time unit later.
    always begin : compare
        bit                   s_r, s_f, s_af;
        logic [NCH*WIDTH-1:0] s_req;
        logic [NCH-1:0]       mp;
        @(posedge clk);
        s_r = reset; s_f = full; s_af = almost_full; s_req = request;
        #1;
        model_step(s_r, s_f, s_af, s_req);
        for (int c = 0; c < NCH; c++) mp[c] = m_pend[c];
        check("cyc_write", 64'(write), 64'(m_write));
        check("cyc_dataOut", 64'(dataOut), 64'(m_data));
        check("cyc_issue_ch", 64'(issue_ch), 64'(m_ch));
        check("cyc_pending", 64'(pending), 64'(mp));
`ifdef REQ_STATS_EN
        check("cyc_issue_count", 64'(issue_count), 64'(m_issue_cnt));
        check("cyc_stall_count", 64'(stall_count), 64'(m_stall_cnt));
`endif
        if (verbose && write) $display("write ch=%0d data=0x%04h t=%0t", issue_ch, dataOut, $time);
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int c, input logic [15:0] w);
        request[c*WIDTH +: WIDTH] = w;
    endtask

    logic [15:0] words_a [NCH];
    logic [15:0] words_b [NCH];
    int          order_b [NCH];
    int          cnt;
    int          cyc;

    initial begin
        words_a = '{16'h0001, 16'h0103, 16'h0205, 16'h0307};
        words_b = '{16'h0003, 16'h0105, 16'h0207, 16'h0309};
        order_b = '{2, 3, 0, 1};
        reset = 1'b1; full = 1'b0; almost_full = 1'b0; request = '0;
        step(3);
        check("rst_write", 64'(write), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_dataOut", 64'(dataOut), 64'd0);
        check("rst_issue_ch", 64'(issue_ch), 64'd0);
        reset = 1'b0;

        // All four channels captured together: ch0..ch3 in order from reset priority.
        for (int c = 0; c < NCH; c++) set_ch(c, words_a[c]);
        step(1);
        check("all_cap_pending", 64'(pending), 64'hF);
        request = '0;
        for (int i = 0; i < NCH; i++) begin
            step(1);
            check("rr0_write", 64'(write), 64'd1);
            check("rr0_ch", 64'(issue_ch), 64'(i));
            check("rr0_data", 64'(dataOut), 64'(words_a[i]));
        end
        step(1);
        check("rr0_done", 64'(write), 64'd0);

        // Single uncontended request: write exactly two cycles later, for one cycle.
        set_ch(1, 16'h0A01);
        step(1);
        check("lat_early", 64'(write), 64'd0);
        request = '0;
        step(1);
        check("lat_write", 64'(write), 64'd1);
        check("lat_data", 64'(dataOut), 64'h0A01);
        check("lat_ch", 64'(issue_ch), 64'd1);
        step(1);
        check("lat_single", 64'(write), 64'd0);

        // last_grant is now 1: order must be ch2, ch3, ch0, ch1.
        for (int c = 0; c < NCH; c++) set_ch(c, words_b[c]);
        step(1);
        request = '0;
        for (int i = 0; i < NCH; i++) begin
            step(1);
            check("rr1_write", 64'(write), 64'd1);
            check("rr1_ch", 64'(issue_ch), 64'(order_b[i]));
            check("rr1_data", 64'(dataOut), 64'(words_b[order_b[i]]));
        end
        step(1);

        // Held word issues once; re-presenting it after a drop is suppressed.
        set_ch(2, 16'h0A01);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin step(1); if (write) cnt++; end
        check("held_once", 64'(cnt), 64'd1);
        request = '0;
        step(2);
        set_ch(2, 16'h0A01);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin step(1); if (write) cnt++; end
        check("repeat_suppressed", 64'(cnt), 64'd0);
        request = '0;

        // FIFO full holds off the write; it goes out on the edge after full falls.
        full = 1'b1;
        set_ch(2, 16'h0B01);
        step(1);
        request = '0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin step(1); if (write) cnt++; end
        check("full_blocks", 64'(cnt), 64'd0);
        check("full_pending", 64'(pending[2]), 64'd1);
        full = 1'b0;
        step(1);
        check("full_release_write", 64'(write), 64'd1);
        check("full_release_data", 64'(dataOut), 64'h0B01);
        step(1);

        // almost_full during back-to-back writes suppresses the next write.
        set_ch(0, 16'h0D01); set_ch(1, 16'h0D03); set_ch(2, 16'h0D05); set_ch(3, 16'h0D07);
        step(1);
        request = '0;
        step(1);
        check("b2b_w1", 64'(write), 64'd1);
        step(1);
        check("b2b_w2", 64'(write), 64'd1);
        almost_full = 1'b1;
        step(1);
        check("af_suppress", 64'(write), 64'd0);
        almost_full = 1'b0;
        step(1);
        check("b2b_w3", 64'(write), 64'd1);
        step(1);
        check("b2b_w4", 64'(write), 64'd1);
        step(1);

        // Reset with pending=1011 discards everything.
        full = 1'b1;
        set_ch(0, 16'h0E01); set_ch(1, 16'h0E03); set_ch(3, 16'h0E07);
        step(1);
        request = '0;
        step(1);
        check("pre_rst_pending", 64'(pending), 64'hB);
        reset = 1'b1;
        step(1);
        check("mid_rst_pending", 64'(pending), 64'd0);
        check("mid_rst_write", 64'(write), 64'd0);
        reset = 1'b0; full = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin step(1); if (write) cnt++; end
        check("post_rst_no_issue", 64'(cnt), 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 1) == 1)
                    set_ch(c, 16'(($urandom_range(0, 3) << 4) | $urandom_range(0, 1)));
            end
            full        = ($urandom_range(0, 3) == 0);
            almost_full = full | ($urandom_range(0, 3) == 0);
            reset       = ($urandom_range(0, 199) == 0);
            step(1);
        end
        reset = 1'b1; full = 1'b0; almost_full = 1'b0; request = '0;
        step(1);
        reset = 1'b0;
        step(2);

`ifdef REQ_STATS_EN
        // 20 stalled cycles with a pending channel.
        full = 1'b1;
        set_ch(0, 16'h0F01);
        step(1);
        request = '0;
        step(20);
        check("stall_count_20", 64'(stall_count), 64'd20);
        full = 1'b0;
        step(3);

        // 70000 writes: issue_count wraps to 4464.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        verbose = 1'b0;
        cnt = 0;
        cyc = 0;
        while (cnt < 70000 && cyc < 80000) begin
            for (int c = 0; c < NCH; c++) set_ch(c, 16'((((cyc * NCH) + c) << 1) | 1));
            step(1);
            cyc++;
            if (write) cnt++;
            if (cnt == 70000) begin
                full = 1'b1; almost_full = 1'b1;
            end
        end
        check("write_budget", 64'(cnt), 64'd70000);
        step(1);
        check("issue_count_wrap", 64'(issue_count), 64'd4464);
        full = 1'b0; almost_full = 1'b0; request = '0;
        step(6);
        verbose = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_channel_requester.md
MULTI_CHANNEL_REQUESTER -- requirements
Module: multi_channel_requester

Interface
REQ-001 The block SHALL have parameter ID, default 0: requester node identifier; stored for system use only, with no effect on the datapath.
REQ-002 The block SHALL have parameter WIDTH, default 16: request word width.
REQ-003 The block SHALL have parameter NCH, default 4, legal range 1..16: number of request channels.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port full, input, 1 bit: the NoC request FIFO is full.
REQ-007 The block SHALL have port almost_full, input, 1 bit: the NoC request FIFO has one free entry or fewer.
REQ-008 The block SHALL have port request, input, NCH*WIDTH bits: channel c occupies bits [c*WIDTH +: WIDTH]; bit 0 of each word is its valid bit.
REQ-009 The block SHALL have port dataOut, output, WIDTH bits: issued request word.
REQ-010 The block SHALL have port write, output, 1 bit: write strobe to the NoC request FIFO.
REQ-011 The block SHALL have port issue_ch, output, max(1,$clog2(NCH)) bits: the channel issued on this write.
REQ-012 The block SHALL have port pending, output, NCH bits: per-channel captured-but-not-issued flag.

Function
REQ-013 Capture: the block SHALL capture channel c when request_c[0]==1, request_c != pre_request_c, and pending[c]==0; it SHALL then set pending[c]<=1, hold_c<=request_c, and pre_request_c<=request_c.
REQ-014 The block SHALL NOT update pre_request_c when request_c[0] drops; an identical word re-presented later SHALL be suppressed.
REQ-015 A distinct word presented while pending[c]==1 SHALL NOT be captured, and SHALL NOT be lost if held; it is captured on the first cycle pending[c]==0 is observed.
REQ-016 Stall: the block SHALL define stall = (write & almost_full) | (~write & full), evaluated on registered write.
REQ-017 Issue: when stall==0 and pending is non-zero, the block SHALL select channel g by round-robin starting at last_grant+1 mod NCH, then set write<=1, dataOut<=hold_g, issue_ch<=g, pending[g]<=0, and last_grant<=g.
REQ-018 Otherwise the block SHALL set write<=0 and dataOut<=0; issue_ch SHALL hold its value.
REQ-019 Latency from request presented to write asserted SHALL be exactly 2 cycles when the channel is uncontended and unstalled.
REQ-020 Aggregate throughput SHALL be 1 write per cycle; each channel SHALL issue at most 1 write per 2 cycles.
REQ-021 Capture and issue in the same cycle on different channels SHALL both take effect; a channel cleared by issue SHALL be re-capturable from the following cycle only.
REQ-022 With NCH==1 the arbiter SHALL degenerate to a fixed grant of channel 0.
REQ-023 Round-robin SHALL guarantee each pending channel issues within NCH unstalled cycles.

Reset
REQ-024 On reset==1 at a clock edge, the block SHALL clear dataOut, write, issue_ch, pending, all hold_c, and all pre_request_c to 0, and set last_grant to NCH-1 so that channel 0 has first priority.
REQ-025 Reset mid-operation SHALL discard pending requests without issuing them.

Configuration
REQ-026 With macro REQ_STATS_EN defined, the block SHALL add output issue_count[15:0], incremented on every write==1 cycle and wrapping at 0xFFFF->0.
REQ-027 With REQ_STATS_EN defined, the block SHALL add output stall_count[15:0], incremented on every cycle with pending!=0 and stall==1, saturating at 0xFFFF; both counters SHALL be cleared by reset.
REQ-028 Without REQ_STATS_EN, the block SHALL have neither port nor counter logic.

Verification (WIDTH=16, NCH=4)
REQ-029 Ch1 presents 0x0A01 for 1 cycle, FIFO empty -> write=1, dataOut=0x0A01, issue_ch=1 exactly 2 cycles later, for 1 cycle only.
REQ-030 Ch1 holds 0x0A01 for 10 cycles -> exactly one write.
REQ-031 Ch1 then deasserts and re-presents 0x0A01 -> no write.
REQ-032 Ch0..3 capture 0x0001, 0x0103, 0x0205, 0x0307 in the same cycle -> 4 consecutive writes in order ch0, ch1, ch2, ch3.
REQ-033 Repeating with last_grant=1 -> order ch2, ch3, ch0, ch1.
REQ-034 full=1 with ch2 pending -> write stays 0; full falls -> write on the next edge.
REQ-035 almost_full rising during back-to-back writes -> the next write is suppressed.
REQ-036 Reset asserted with pending=4'b1011 -> pending=0, write=0 next edge, and no issue after release.
REQ-037 REQ_STATS_EN defined, 70000 writes -> issue_count=70000 mod 65536=4464.
REQ-038 REQ_STATS_EN defined, 20 stalled pending cycles -> stall_count=20.
